// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready stalls and a sticky illegal-opcode flag.
// Define MC_ADDI_EN to compile in the addi states (ADDIEX/ADDIWB); otherwise addi is treated as illegal.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    state_t r_state;
    logic   r_illegal;
    state_t w_next;
    logic   w_setIllegal;

    logic       w_pcWrite, w_irWrite, w_memRead, w_memWrite, w_regWrite;
    logic       w_pcWriteCond, w_iorD, w_memtoReg, w_aluSrcA, w_regDst;
    logic [1:0] w_pcSource, w_aluSrcB, w_aluOp;

    always_comb begin
        w_next       = S_FETCH;
        w_setIllegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_next = S_ADDIEX;
`endif
                    default: begin
                        w_next       = S_FETCH;
                        w_setIllegal = 1'b1;
                    end
                endcase
            end
            // IR is held through MEMADR, so the opcode still selects load vs store here
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_iorD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_memtoReg    = 1'b0;
        w_irWrite     = 1'b0;
        w_aluSrcA     = 1'b0;
        w_regWrite    = 1'b0;
        w_regDst      = 1'b0;
        w_pcSource    = 2'b00;
        w_aluSrcB     = 2'b00;
        w_aluOp       = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_aluSrcB = 2'b01;
                w_irWrite = mem_ready;
                w_pcWrite = mem_ready;
            end
            S_DECODE: w_aluSrcB = 2'b11;
            S_MEMADR: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                w_memRead = 1'b1;
                w_iorD    = 1'b1;
            end
            S_MEMWB: begin
                w_regWrite = 1'b1;
                w_memtoReg = 1'b1;
            end
            S_MEMWR: begin
                w_memWrite = 1'b1;
                w_iorD     = 1'b1;
            end
            S_EXEC: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = 2'b10;
            end
            S_RWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
            end
            S_BRANCH: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = 2'b01;
                w_pcWriteCond = 1'b1;
                w_pcSource    = 2'b01;
            end
            S_JUMP: begin
                w_pcWrite  = 1'b1;
                w_pcSource = 2'b10;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_ADDIWB: w_regWrite = 1'b1;
`endif
            default: ;
        endcase
    end

    // Write enables are killed while rst is high so an aborted instruction never commits
    assign PCWrite     = w_pcWrite  & ~rst;
    assign IRWrite     = w_irWrite  & ~rst;
    assign MemRead     = w_memRead  & ~rst;
    assign MemWrite    = w_memWrite & ~rst;
    assign RegWrite    = w_regWrite & ~rst;
    assign PCWriteCond = w_pcWriteCond;
    assign IorD        = w_iorD;
    assign MemtoReg    = w_memtoReg;
    assign ALUSrcA     = w_aluSrcA;
    assign RegDst      = w_regDst;
    assign PCSource    = w_pcSource;
    assign ALUSrcB     = w_aluSrcB;
    assign ALUOp       = w_aluOp;
    assign state       = r_state;
    assign illegal     = r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_setIllegal)
                r_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: random instruction stream with random memory stalls,
// checked cycle by cycle against a path/table model of the instruction set.
module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] state;
    logic       illegal;

    int testCount = 0;
    int failCount = 0;
    bit modelIll  = 1'b0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLegal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010: return 1'b1;
`ifdef MC_ADDI_EN
            6'b001000: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Expected control word for a state: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp}
    function automatic logic [15:0] expCtl(input int s, input bit mr, input bit rstv);
        bit pw = 0, pwc = 0, iord = 0, mrd = 0, mw = 0, m2r = 0, irw = 0, asa = 0, rw = 0, rd = 0;
        logic [1:0] pcs = 2'b00, asb = 2'b00, aop = 2'b00;
        case (s)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
            9:  begin pw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        if (rstv) begin
            pw = 0; irw = 0; mrd = 0; mw = 0; rw = 0;
        end
        return {pw, pwc, iord, mrd, mw, m2r, irw, asa, rw, rd, pcs, asb, aop};
    endfunction

    function automatic logic [15:0] obsCtl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int s, input bit mr, input bit rstv);
        checkOutput({tag, " state"}, {12'd0, state}, 16'(s));
        checkOutput({tag, " ctl"}, obsCtl(), expCtl(s, mr, rstv));
        checkOutput({tag, " illegal"}, {15'd0, illegal}, {15'd0, modelIll});
    endtask

    // One clock cycle: drive mem_ready, check at the falling edge, then step past the rising edge
    task automatic applyStimulus(input int s, input bit mr);
        mem_ready = mr;
        @(negedge clk);
        checkAll($sformatf("st%0d", s), s, mr, 1'b0);
        @(posedge clk);
        #1;
    endtask

    function automatic void buildPath(input logic [5:0] op, output int path[$]);
        path = {0, 1};
        case (op)
            6'b100011: path = {0, 1, 2, 3, 4};
            6'b101011: path = {0, 1, 2, 5};
            6'b000000: path = {0, 1, 6, 7};
            6'b000100: path = {0, 1, 8};
            6'b000010: path = {0, 1, 9};
            default:   if (isLegal(op)) path = {0, 1, 10, 11};
        endcase
    endfunction

    // Runs one instruction; memwrStalls >= 0 forces that many not-ready cycles in MEMWR
    task automatic runInstr(input logic [5:0] op, input int memwrStalls);
        int path[$];
        int stalls;
        buildPath(op, path);
        opcode = op;
        foreach (path[i]) begin
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                stalls = (path[i] == 5 && memwrStalls >= 0) ? memwrStalls : int'($urandom_range(0, 2));
                repeat (stalls) applyStimulus(path[i], 1'b0);
                applyStimulus(path[i], 1'b1);
            end else begin
                applyStimulus(path[i], 1'($urandom_range(0, 1)));
            end
            if (path[i] == 1 && !isLegal(op))
                modelIll = 1'b1;
        end
    endtask

    initial begin
        logic [5:0] ops[7];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};

        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        #1;
        checkAll("reset", 0, 1'b1, 1'b1);
        mem_ready = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed program: lw, R-type, sw with three MEMWR stalls, beq, j, illegal, addi
        runInstr(6'b100011, -1);
        runInstr(6'b000000, -1);
        runInstr(6'b101011, 3);
        runInstr(6'b000100, -1);
        runInstr(6'b000010, -1);
        runInstr(6'b111111, -1);
        runInstr(6'b100011, -1);
        runInstr(6'b001000, -1);

        // Random instruction stream with random stalls
        for (int n = 0; n < 40; n++)
            runInstr((n % 5 == 4) ? 6'($urandom) : ops[$urandom_range(0, 6)], -1);

        // Abort a store mid-MEMWR with rst; write enables must drop at once
        runInstr(6'b000000, -1);
        opcode = 6'b101011;
        applyStimulus(0, 1'b1);
        applyStimulus(1, 1'b1);
        applyStimulus(2, 1'b1);
        mem_ready = 1'b0;
        #2;
        checkAll("memwr_pre_rst", 5, 1'b0, 1'b0);
        rst = 1'b1;
        mem_ready = 1'b1;
        modelIll = 1'b0;
        #1;
        checkAll("memwr_rst", 0, 1'b1, 1'b1);
        mem_ready = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        runInstr(6'b000010, -1);
        runInstr(6'b100011, -1);
        applyStimulus(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode over several clock cycles and drives every datapath enable and mux select, including the 2-bit `ALUOp` consumed by the ALU control stage. A memory-ready handshake stretches fetch and data-memory states. Unsupported opcodes are flagged and the instruction is skipped.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  `IR[31:26]`; sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls.
- `PCSource`  out  2  `00` ALU result, `01` ALUOut, `10` jump target.
- `ALUSrcB`  out  2  `00` reg B, `01` constant 4, `10` sign-extended immediate, `11` shifted immediate.
- `ALUOp`  out  2  `00` add, `01` subtract, `10` use funct.
- `state`  out  4  current state encoding, for debug.
- `illegal`  out  1  sticky unsupported-opcode flag.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
  - Encodings 12–15 are unused and go to FETCH on the next edge.
- Outputs are decoded from `state`. Any control not listed for a state is 0.
- FETCH:
  - `MemRead=1`, `ALUSrcB=01`, `ALUOp=00`, `PCSource=00`.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Goes to DECODE when `mem_ready=1`; otherwise stays in FETCH.
- DECODE: `ALUSrcB=11`, `ALUOp=00`. Next state by opcode:
  - `100011` (lw) or `101011` (sw) → MEMADR.
  - `000000` → EXEC.
  - `000100` (beq) → BRANCH.
  - `000010` (j) → JUMP.
  - `001000` (addi) → ADDIEX. Only when built with the addi feature.
  - Anything else → FETCH, and `illegal` is set.
- MEMADR: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Goes to MEMRD for lw, MEMWR for sw. The opcode is still valid because IR is held.
- MEMRD: `MemRead=1`, `IorD=1`. Goes to MEMWB when `mem_ready=1`; otherwise holds.
- MEMWB: `RegWrite=1`, `MemtoReg=1`, `RegDst=0`. Goes to FETCH.
- MEMWR: `MemWrite=1`, `IorD=1`. Goes to FETCH when `mem_ready=1`; otherwise holds. `MemWrite` stays high for the whole hold.
- EXEC: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`. Goes to RWB.
- RWB: `RegWrite=1`, `RegDst=1`, `MemtoReg=0`. Goes to FETCH.
- BRANCH: `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `PCWriteCond=1`, `PCSource=01`. Goes to FETCH.
- JUMP: `PCWrite=1`, `PCSource=10`. Goes to FETCH.
- `illegal`:
  - Registered and sticky: set on the edge leaving DECODE with an unsupported opcode.
  - Cleared only by `rst`.

## Timing
- Reset behaviour:
  - `rst` high forces `state=FETCH` and `illegal=0` asynchronously.
  - While `rst` is high, `PCWrite`, `IRWrite`, `MemRead`, `MemWrite` and `RegWrite` are gated to 0 combinationally. The other outputs show their FETCH values.
  - Deasserting `rst` resumes at FETCH on the next edge.
  - Asserting `rst` mid-instruction aborts it immediately. No write enable stays high after `rst` rises.
- Cycle counts with `mem_ready` held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each `mem_ready=0` cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in all other states.

## Configuration
- Macro `MC_ADDI_EN`:
  - Defined: ADDIEX and ADDIWB are compiled in.
    - ADDIEX: `ALUSrcA=1`, `ALUSrcB=10`, `ALUOp=00`. Goes to ADDIWB.
    - ADDIWB: `RegWrite=1`, `RegDst=0`, `MemtoReg=0`. Goes to FETCH.
  - Undefined: those states do not exist. Encodings 10 and 11 behave as unused states, and opcode `001000` is illegal.

## Test plan
- Reset then lw `100011` with `mem_ready=1` → state sequence 0,1,2,3,4,0. `RegWrite=1` and `MemtoReg=1` only in state 4.
- R-type `000000` → state 6 shows `ALUOp=10`, `ALUSrcB=00`. State 7 shows `RegWrite=1`, `RegDst=1`. Back to 0 after 4 cycles.
- sw `101011` with `mem_ready` low 3 cycles in MEMWR → `MemWrite=1` for 4 consecutive cycles, then FETCH.
- beq `000100` → state 8 shows `ALUOp=01`, `PCWriteCond=1`, `PCSource=01`. j `000010` → state 9 shows `PCWrite=1`, `PCSource=10`.
- Opcode `111111` → FETCH 2 cycles after FETCH start, `illegal=1` and stays 1 through later valid instructions until `rst`.
- Assert `rst` during MEMWR with `MemWrite=1` → `MemWrite=0` and `state=0` in the same cycle. Addi `001000` gives 4 cycles with `MC_ADDI_EN` defined, and sets `illegal` without it.
